mux_pipe_nto1: RTL

Parametrised N-to-1 datapath operand selector with a registered, back-pressurable output. It generalises the fixed 32-bit 3-to-1 select used in the datapath to any width and input count. It adds a valid/ready handshake with a two-entry skid buffer, a flush, and detection of out-of-range selects. It sits between pipeline stages wherever a forwarding or operand mux must also absorb a downstream stall.

---
 rtl/mux_pipe_nto1_if.sv | 27 ++
 rtl/mux_pipe_nto1.sv | 112 +++++++++++
 2 files changed

// File: rtl/mux_pipe_nto1_if.sv
// Handshake bundle for mux_pipe_nto1: upstream select/offer side and downstream output side.
interface mux_pipe_nto1_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_count;

  modport master (
    output in_bus, sel, in_valid, flush, out_ready,
    input  in_ready, out, out_valid, sel_err, err_count
  );

  modport slave (
    input  in_bus, sel, in_valid, flush, out_ready,
    output in_ready, out, out_valid, sel_err, err_count
  );
endinterface

// File: rtl/mux_pipe_nto1.sv
// N-to-1 operand select feeding a two-entry skid buffer (main + skid) with flush and
// out-of-range select detection. All outputs come straight from registers.
module mux_pipe_nto1 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input logic             Clk,
  input logic             Rst,
  mux_pipe_nto1_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             transfer;

  // Any select value not matching a real input yields a zero word and flags an error.
  always_comb begin
    sel_word = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_word = bus.in_bus[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = bus.in_valid & in_ready;
  assign transfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    sel_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      if (accept && sel_bad) begin
        sel_err_d = 1'b1;
        if (err_count_q != 8'hff) begin
          err_count_d = err_count_q + 8'd1;
        end
      end

      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = sel_word;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && !transfer) begin
            skid_d  = sel_word;
            state_d = StFull;
          end else if (transfer && !accept) begin
            state_d = StEmpty;
          end else if (accept && transfer) begin
            main_d = sel_word;
          end
        end
        StFull: begin
          if (transfer) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = main_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_count_q;

endmodule
